// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end types and widths used by the fetch queue and its bench.
package legv8_pkg;

    localparam int ADDR_WIDTH  = 64;
    localparam int INSTR_WIDTH = 32;
    localparam int INSTR_BYTES = 4;
    localparam int FETCH_WIDTH = 2;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'hD503_201F;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode-side bus of the fetch queue: IC address/data, redirect and the two issue slots.
interface fetch_queue_if;
    import legv8_pkg::*;

    logic [ADDR_WIDTH-1:0]  PC_out;
    logic [INSTR_WIDTH-1:0] IC_in0;
    logic [INSTR_WIDTH-1:0] IC_in1;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic [1:0]             deq_count;
    logic                   out_valid0;
    logic [INSTR_WIDTH-1:0] out_instr0;
    logic [ADDR_WIDTH-1:0]  out_pc0;
    logic                   out_valid1;
    logic [INSTR_WIDTH-1:0] out_instr1;
    logic [ADDR_WIDTH-1:0]  out_pc1;
    logic                   fetch_stall;

    modport master (
        output PC_out,
        input  IC_in0, IC_in1,
        input  redirect_valid, redirect_pc, deq_count,
        output out_valid0, out_instr0, out_pc0,
        output out_valid1, out_instr1, out_pc1,
        output fetch_stall
    );

    modport slave (
        input  PC_out,
        output IC_in0, IC_in1,
        output redirect_valid, redirect_pc, deq_count,
        input  out_valid0, out_instr0, out_pc0,
        input  out_valid1, out_instr1, out_pc1,
        input  fetch_stall
    );

endinterface

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: two write ports (tail, tail+1), two async read ports.
module fetch_queue_ram
    import legv8_pkg::fetch_entry_t;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we0,
    input  logic [PTR_W-1:0] waddr0,
    input  fetch_entry_t     wdata0,
    input  logic             we1,
    input  logic [PTR_W-1:0] waddr1,
    input  fetch_entry_t     wdata1,
    input  logic [PTR_W-1:0] raddr0,
    output fetch_entry_t     rdata0,
    input  logic [PTR_W-1:0] raddr1,
    output fetch_entry_t     rdata1
);

    fetch_entry_t mem [DEPTH];

    // NOTE: the array has no reset; validity lives in the count register, so stale
    // contents are never presented and the storage can map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue: fetches two sequential words per cycle from the IC,
// buffers them with their PCs and presents the two oldest to decode; flushes on redirect.
module fetch_queue
    import legv8_pkg::fetch_entry_t;
    import legv8_pkg::INSTR_BYTES;
    import legv8_pkg::FETCH_WIDTH;
#(
    parameter int                    DEPTH       = 8,
    parameter int                    ADDR_WIDTH  = legv8_pkg::ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = legv8_pkg::INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic          CLOCK,
    input  logic          RESET,
    fetch_queue_if.master bus
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t FETCH_C = cnt_t'(FETCH_WIDTH);

    ptr_t                  head_q, tail_q;
    cnt_t                  count_q;
    logic [ADDR_WIDTH-1:0] pc_q;

    cnt_t                  free_slots, enq_n, deq_n;
    logic [1:0]            deq_req;
    ptr_t                  head_p1, tail_p1;
    fetch_entry_t          wdata0, wdata1, rdata0, rdata1;
    logic                  we0, we1;

    // Low PC bits of a redirect target are discarded; words are always 4-byte aligned.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        deq_req    = (bus.deq_count == 2'd3) ? 2'd2 : bus.deq_count;
        free_slots = DEPTH_C - count_q;
        enq_n      = '0;
        deq_n      = '0;
        if (!bus.redirect_valid) begin
            // Free space is judged before this cycle's dequeue, so a full queue stalls
            // for one cycle even when decode drains it.
            if (free_slots >= FETCH_C)   enq_n = FETCH_C;
            else if (free_slots != '0)   enq_n = cnt_t'(1);
            deq_n = (cnt_t'(deq_req) > count_q) ? count_q : cnt_t'(deq_req);
        end
    end

    assign head_p1 = head_q + ptr_t'(1);
    assign tail_p1 = tail_q + ptr_t'(1);

    assign we0    = !RESET && (enq_n != '0);
    assign we1    = !RESET && (enq_n == FETCH_C);
    assign wdata0 = '{pc: pc_q,                                 instr: bus.IC_in0};
    assign wdata1 = '{pc: pc_q + ADDR_WIDTH'(INSTR_BYTES),      instr: bus.IC_in1};

    fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
        .clk    (CLOCK),
        .we0    (we0),
        .waddr0 (tail_q),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (tail_p1),
        .wdata1 (wdata1),
        .raddr0 (head_q),
        .rdata0 (rdata0),
        .raddr1 (head_p1),
        .rdata1 (rdata1)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (bus.redirect_valid) begin
            pc_q    <= {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            pc_q    <= pc_q + ADDR_WIDTH'(enq_n) * ADDR_WIDTH'(INSTR_BYTES);
            count_q <= count_q + enq_n - deq_n;
            head_q  <= head_q + ptr_t'(deq_n);
            tail_q  <= tail_q + ptr_t'(enq_n);
        end
    end

    assign bus.PC_out      = pc_q;
    assign bus.out_valid0  = (count_q != '0);
    assign bus.out_valid1  = (count_q >= cnt_t'(2));
    assign bus.out_instr0  = bus.out_valid0 ? rdata0.instr : '0;
    assign bus.out_pc0     = bus.out_valid0 ? rdata0.pc    : '0;
    assign bus.out_instr1  = bus.out_valid1 ? rdata1.instr : '0;
    assign bus.out_pc1     = bus.out_valid1 ? rdata1.pc    : '0;
    assign bus.fetch_stall = (count_q == DEPTH_C) && !bus.redirect_valid && !RESET;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/stall, odd free slot, wrap, redirect, deq clamp.
module tb_fetch_queue;
    import legv8_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    fetch_queue_if ifc ();

    fetch_queue #(
        .DEPTH      (8),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INSTR_WIDTH(INSTR_WIDTH),
        .RESET_PC   (64'h0)
    ) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (ifc.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ic_word(input logic [63:0] pc);
        return 32'h9100_0000 ^ pc[31:0];
    endfunction

    // Combinational instruction memory model; NOPs while in reset.
    always @* begin
        ifc.IC_in0 = rst ? NOP_INSTR : ic_word(ifc.PC_out);
        ifc.IC_in1 = rst ? NOP_INSTR : ic_word(ifc.PC_out + 64'd4);
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_slots(input string tag, input logic [63:0] pc0, input logic [63:0] pc1);
        check({tag, ".pc0"},    ifc.out_pc0,    pc0);
        check({tag, ".instr0"}, ifc.out_instr0, 64'(ic_word(pc0)));
        check({tag, ".pc1"},    ifc.out_pc1,    pc1);
        check({tag, ".instr1"}, ifc.out_instr1, 64'(ic_word(pc1)));
    endtask

    initial begin
        rst                = 1'b1;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = '0;
        ifc.deq_count      = 2'd0;
        step();
        step();
        check("rst.pc_out", ifc.PC_out,      64'h0);
        check("rst.valid0", ifc.out_valid0,  1'b0);
        check("rst.valid1", ifc.out_valid1,  1'b0);
        check("rst.stall",  ifc.fetch_stall, 1'b0);
        check("rst.instr0", ifc.out_instr0,  64'h0);
        check("rst.pc0",    ifc.out_pc0,     64'h0);

        // First fetch visible one cycle later.
        rst = 1'b0;
        step();
        check("first.valid0", ifc.out_valid0, 1'b1);
        check("first.valid1", ifc.out_valid1, 1'b1);
        check_slots("first", 64'h0, 64'h4);
        check("first.pc_out", ifc.PC_out, 64'd8);

        // Fill to DEPTH with no dequeue.
        step(); step(); step();
        check("full.pc_out", ifc.PC_out,      64'd32);
        check("full.stall",  ifc.fetch_stall, 1'b1);
        step();
        check("held.pc_out", ifc.PC_out,  64'd32);
        check("held.pc0",    ifc.out_pc0, 64'd0);

        // Dequeue one from full: conservative free count means no enqueue.
        ifc.deq_count = 2'd1;
        step();
        check_slots("deq1", 64'd4, 64'd8);
        check("deq1.pc_out", ifc.PC_out,      64'd32);
        check("deq1.stall",  ifc.fetch_stall, 1'b0);

        // One free slot: single enqueue.
        ifc.deq_count = 2'd0;
        step();
        check("odd.pc_out", ifc.PC_out,      64'd36);
        check("odd.pc0",    ifc.out_pc0,     64'd4);
        check("odd.stall",  ifc.fetch_stall, 1'b1);

        // Dual dequeue across the pointer wrap.
        ifc.deq_count = 2'd2;
        step();
        check_slots("wrapA", 64'd12, 64'd16);
        check("wrapA.pc_out", ifc.PC_out, 64'd36);
        step();
        check_slots("wrapB", 64'd20, 64'd24);
        check("wrapB.pc_out", ifc.PC_out, 64'd44);
        step();
        check_slots("wrapC", 64'd28, 64'd32);
        check("wrapC.pc_out", ifc.PC_out, 64'd52);
        step();
        check_slots("wrapD", 64'd36, 64'd40);
        check("wrapD.pc_out", ifc.PC_out,      64'd60);
        check("wrapD.stall",  ifc.fetch_stall, 1'b0);

        // Refill, then redirect while full.
        ifc.deq_count = 2'd0;
        step();
        check("refill.pc_out", ifc.PC_out,      64'd68);
        check("refill.stall",  ifc.fetch_stall, 1'b1);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 64'h1003;
        #1;
        check("redir.stall", ifc.fetch_stall, 1'b0);
        step();
        check("redir.valid0", ifc.out_valid0, 1'b0);
        check("redir.instr0", ifc.out_instr0, 64'h0);
        check("redir.pc_out", ifc.PC_out,     64'h1000);

        // Resume at the aligned target; over-request on an empty queue is harmless.
        ifc.redirect_valid = 1'b0;
        ifc.deq_count      = 2'd3;
        step();
        check("resume.valid1", ifc.out_valid1, 1'b1);
        check_slots("resume", 64'h1000, 64'h1004);
        check("resume.pc_out", ifc.PC_out, 64'h1008);

        // Steady dual issue from count=2.
        step();
        check_slots("dual", 64'h1008, 64'h100C);
        check("dual.pc_out", ifc.PC_out, 64'h1010);

        // Grow to count=3, then deq_count=3 must consume only two.
        ifc.deq_count = 2'd1;
        step();
        check_slots("grow", 64'h100C, 64'h1010);
        ifc.deq_count = 2'd3;
        step();
        check_slots("clamp", 64'h1014, 64'h1018);
        check("clamp.pc_out", ifc.PC_out, 64'h1020);
        ifc.deq_count = 2'd2;
        step();
        check("steady1.pc0",   ifc.out_pc0,     64'h101C);
        step();
        check("steady2.pc0",   ifc.out_pc0,     64'h1024);
        check("steady2.stall", ifc.fetch_stall, 1'b0);

        // Reset wins over a simultaneous redirect.
        rst                = 1'b1;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 64'h2000;
        #1;
        check("rstredir.stall", ifc.fetch_stall, 1'b0);
        step();
        check("rstredir.pc_out", ifc.PC_out,     64'h0);
        check("rstredir.valid0", ifc.out_valid0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
